mult_share_arbiter: RTL and testbench

- Shares one combinational signed_multiplier instance (inputs x, y; output m) between two requesters.
- Each requester has a valid/ready operand channel; one registered response channel returns the product tagged with the requester id.
- Round-robin arbitration; a single-entry output register provides back-pressure.
- Sits between operand producers and the signed multiplier datapath in the arithmetic subsystem.

---
 rtl/mult_share_arbiter.sv | 115 +++++++++++
 tb/tb_mult_share_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_share_arbiter.sv
// Two-requester front end for one shared signed multiplier: round-robin grant,
// single-entry registered response with back-pressure and same-cycle drain/refill.

module signed_multiplier #(
    parameter int N = 4
) (
    input  logic [N-1:0]   x,
    input  logic [N-1:0]   y,
    output logic [2*N-1:0] m
);
    logic [2*N-1:0] x_ext;
    logic [2*N-1:0] y_ext;

    // Sign-extending to 2N first keeps the low 2N bits of the product exact.
    assign x_ext = {{N{x[N-1]}}, x};
    assign y_ext = {{N{y[N-1]}}, y};
    assign m     = x_ext * y_ext;
endmodule

module mult_share_arbiter #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [N-1:0]   req0_x,
    input  logic [N-1:0]   req0_y,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [N-1:0]   req1_x,
    input  logic [N-1:0]   req1_y,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [2*N-1:0] rsp_m,
    output logic           rsp_id
);
    // Handshake rule: a transfer happens on a rising edge where valid and ready
    // are both high; ready may depend on valid, valid must never depend on ready.

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic           prio_q, prio_d;
    logic [2*N-1:0] m_q, m_d;
    logic           id_q, id_d;

    logic           can_accept;
    logic           grant_valid;
    logic           grant_id;
    logic           accept;
    logic [N-1:0]   mul_x;
    logic [N-1:0]   mul_y;
    logic [2*N-1:0] mul_m;

    always_comb begin
        grant_valid = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            grant_id = prio_q;
        end else begin
            grant_id = req1_valid;
        end
    end

    assign can_accept = (state_q == EMPTY) || rsp_ready;
    assign accept     = can_accept && grant_valid;
    assign req0_ready = accept && !grant_id;
    assign req1_ready = accept && grant_id;

    // With no grant the mux falls back to requester 0; the result is discarded.
    assign mul_x = (grant_valid && grant_id) ? req1_x : req0_x;
    assign mul_y = (grant_valid && grant_id) ? req1_y : req0_y;

    signed_multiplier #(.N(N)) u_mul (
        .x (mul_x),
        .y (mul_y),
        .m (mul_m)
    );

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        m_d     = m_q;
        id_d    = id_q;
        if (accept) begin
            state_d = FULL;
            m_d     = mul_m;
            id_d    = grant_id;
            prio_d  = ~grant_id;
        end else if ((state_q == FULL) && rsp_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            prio_q  <= 1'b0;
            m_q     <= '0;
            id_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            m_q     <= m_d;
            id_q    <= id_d;
        end
    end

    assign rsp_valid = (state_q == FULL);
    assign rsp_m     = m_q;
    assign rsp_id    = id_q;
endmodule

// File: tb/tb_mult_share_arbiter.sv
// Randomized scoreboard bench for mult_share_arbiter: driver feeds per-requester
// operand queues, monitor predicts readies and products from a behavioural model.

module tb_mult_share_arbiter;
    localparam int N = 4;
    localparam int W = 2 * N + 1;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           req0_valid = 1'b0;
    logic           req0_ready;
    logic [N-1:0]   req0_x = '0;
    logic [N-1:0]   req0_y = '0;
    logic           req1_valid = 1'b0;
    logic           req1_ready;
    logic [N-1:0]   req1_x = '0;
    logic [N-1:0]   req1_y = '0;
    logic           rsp_valid;
    logic           rsp_ready = 1'b0;
    logic [2*N-1:0] rsp_m;
    logic           rsp_id;

    mult_share_arbiter #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_x     (req0_x),
        .req0_y     (req0_y),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_x     (req1_x),
        .req1_y     (req1_y),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_m      (rsp_m),
        .rsp_id     (rsp_id)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    function automatic void check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [2*N-1:0] prod(input logic [N-1:0] a, input logic [N-1:0] b);
        int p;
        p = int'($signed(a)) * int'($signed(b));
        return p[2*N-1:0];
    endfunction

    // scoreboard / reference model state (owned by the monitor)
    logic [W-1:0]   exp_q[$];
    bit             prio_m = 1'b0;
    bit             full_m = 1'b0;
    bit             hs0 = 1'b0;
    bit             hs1 = 1'b0;
    int             acc_cnt0 = 0;
    int             acc_cnt1 = 0;
    int             rsp_cnt = 0;

    // driver state
    logic [2*N-1:0] src0_q[$];
    logic [2*N-1:0] src1_q[$];
    bit             holding0 = 1'b0;
    bit             holding1 = 1'b0;

    // monitor
    initial begin
        bit can, gv, gid, e0, e1;
        forever begin
            @(negedge clk or negedge rst_n);
            if (!rst_n) begin
                #1;
                check("reset rsp_valid", int'(rsp_valid), 0);
                check("reset rsp_m", int'(rsp_m), 0);
                check("reset rsp_id", int'(rsp_id), 0);
                exp_q.delete();
                prio_m = 1'b0;
                full_m = 1'b0;
                hs0 = 1'b0;
                hs1 = 1'b0;
            end else begin
                can = !full_m || rsp_ready;
                gv  = req0_valid || req1_valid;
                gid = (req0_valid && req1_valid) ? prio_m : req1_valid;
                e0  = can && gv && !gid;
                e1  = can && gv && gid;
                check("req0_ready", int'(req0_ready), int'(e0));
                check("req1_ready", int'(req1_ready), int'(e1));
                check("rsp_valid", int'(rsp_valid), int'(full_m));
                if (rsp_valid) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL rsp_unexpected: got m=%0d id=%0d expected no response at %0t",
                                 $signed(rsp_m), rsp_id, $time);
                    end else begin
                        check("rsp_m", int'($signed(rsp_m)), int'($signed(exp_q[0][2*N-1:0])));
                        check("rsp_id", int'(rsp_id), int'(exp_q[0][2*N]));
                        if (rsp_ready) begin
                            void'(exp_q.pop_front());
                            rsp_cnt++;
                        end
                    end
                end
                hs0 = req0_valid && req0_ready;
                hs1 = req1_valid && req1_ready;
                if (hs0) begin
                    exp_q.push_back({1'b0, prod(req0_x, req0_y)});
                    acc_cnt0++;
                end
                if (hs1) begin
                    exp_q.push_back({1'b1, prod(req1_x, req1_y)});
                    acc_cnt1++;
                end
                if (e0 || e1) begin
                    full_m = 1'b1;
                    prio_m = !gid;
                end else if (rsp_ready) begin
                    full_m = 1'b0;
                end
            end
        end
    end

    // driver tasks
    task automatic drive(input int idle0_pct, input int idle1_pct, input int rdy_pct);
        @(posedge clk);
        #1;
        if (hs0) begin
            void'(src0_q.pop_front());
            holding0 = 1'b0;
        end
        if (hs1) begin
            void'(src1_q.pop_front());
            holding1 = 1'b0;
        end
        if (!holding0 && src0_q.size() > 0 && $urandom_range(99, 0) >= idle0_pct) holding0 = 1'b1;
        if (!holding1 && src1_q.size() > 0 && $urandom_range(99, 0) >= idle1_pct) holding1 = 1'b1;
        req0_valid = holding0;
        req1_valid = holding1;
        if (holding0) {req0_x, req0_y} = src0_q[0];
        else {req0_x, req0_y} = 8'($urandom);
        if (holding1) {req1_x, req1_y} = src1_q[0];
        else {req1_x, req1_y} = 8'($urandom);
        rsp_ready = ($urandom_range(99, 0) < rdy_pct);
    endtask

    task automatic clear_drive();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b0;
        holding0   = 1'b0;
        holding1   = 1'b0;
        src0_q.delete();
        src1_q.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_drive();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int a0, a1, r0, guard;
        #1;
        do_reset();

        // single request, then a both-valid pair that must go to requester 1
        src0_q.push_back({4'h8, 4'h8});
        drive(0, 0, 100);
        drive(0, 0, 100);
        src0_q.push_back({4'd1, 4'd1});
        src1_q.push_back({4'd2, 4'd2});
        repeat (5) drive(0, 0, 100);

        // simultaneous requests straight after reset
        do_reset();
        src0_q.push_back({4'd3, 4'he});
        src1_q.push_back({4'd7, 4'h8});
        repeat (4) drive(0, 0, 100);

        // back-pressure with a pending request, then same-cycle drain and refill
        do_reset();
        src1_q.push_back({4'd7, 4'h8});
        src1_q.push_back({4'hf, 4'hf});
        repeat (6) drive(0, 0, 0);
        repeat (3) drive(0, 0, 100);

        // fairness: both always valid for 20 cycles
        do_reset();
        for (int i = 0; i < 10; i++) begin
            src0_q.push_back(8'($urandom));
            src1_q.push_back(8'($urandom));
        end
        a0 = acc_cnt0;
        a1 = acc_cnt1;
        repeat (20) drive(0, 0, 100);
        repeat (3) drive(0, 0, 100);
        check("fair accepts id0", acc_cnt0 - a0, 10);
        check("fair accepts id1", acc_cnt1 - a1, 10);

        // asynchronous reset while holding a result
        do_reset();
        src0_q.push_back({4'h8, 4'h8});
        repeat (3) drive(0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async rsp_valid", int'(rsp_valid), 0);
        check("async rsp_m", int'(rsp_m), 0);
        clear_drive();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        src0_q.push_back({4'd5, 4'd3});
        src1_q.push_back({4'd2, 4'h9});
        repeat (4) drive(0, 0, 100);

        // exhaustive operand sweep on requester 1 with random req0 traffic
        do_reset();
        for (int i = 0; i < 256; i++) src1_q.push_back(8'(i));
        for (int i = 0; i < 40; i++) src0_q.push_back(8'($urandom));
        a1 = acc_cnt1;
        r0 = rsp_cnt;
        guard = 0;
        while ((src0_q.size() > 0 || src1_q.size() > 0 || exp_q.size() > 0) && guard < 4000) begin
            drive(30, 10, 60);
            guard++;
        end
        repeat (2) drive(0, 0, 100);
        check("sweep timeout", int'(guard >= 4000), 0);
        check("sweep accepts id1", acc_cnt1 - a1, 256);
        check("sweep responses", rsp_cnt - r0, 296);
        check("sweep queue empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
